// File: rtl/cj_pkg.sv
// Shared types and defaults for the commit-trace serializer.
package cj_pkg;

    localparam int unsigned XLEN            = 64;
    localparam int unsigned DEPTH_DEFAULT   = 16;
    localparam int unsigned COMMITS_DEFAULT = 3;

    localparam logic EVENT_KIND_COMMIT = 1'b0;
    localparam logic EVENT_KIND_TRAP   = 1'b1;

    typedef struct packed {
        logic            kind;
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic            wen;
        logic [4:0]      waddr;
        logic [XLEN-1:0] wdata;
    } commit_entry_t;

    // Same fields minus the kind bit, for builds that never queue traps
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic            wen;
        logic [4:0]      waddr;
        logic [XLEN-1:0] wdata;
    } commit_payload_t;

endpackage

// File: rtl/cj_lane_compactor.sv
// Prefix popcount: maps each valid retire lane to its slot offset and
// returns the total event count for the cycle (lanes plus optional trap).
module cj_lane_compactor #(
    parameter int unsigned COMMITS = 3,
    parameter int unsigned CNT_W   = 3
) (
    input  logic [COMMITS-1:0]            i_valid,
    input  logic                          i_trap,
    output logic [COMMITS-1:0][CNT_W-1:0] o_off,
    output logic [CNT_W-1:0]              o_n
);

    always_comb begin
        logic [CNT_W-1:0] w_acc;
        w_acc = '0;
        o_off = '0;
        for (int i = 0; i < COMMITS; i++) begin
            o_off[i] = w_acc;
            w_acc    = w_acc + CNT_W'(i_valid[i]);
        end
        o_n = w_acc + CNT_W'(i_trap);
    end

endmodule

// File: rtl/cj_commit_serializer.sv
// Serializes multi-lane retire events into an in-order, numbered stream.
// Trap capture is enabled by defining CJ_COMMIT_TRAP_EN.
module cj_commit_serializer
    import cj_pkg::*;
#(
    parameter int unsigned COMMITS = COMMITS_DEFAULT,
    parameter int unsigned DEPTH   = DEPTH_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [COMMITS-1:0]      in_valid,
    input  logic [COMMITS*XLEN-1:0] in_pc,
    input  logic [COMMITS*32-1:0]   in_insn,
    input  logic [COMMITS-1:0]      in_wen,
    input  logic [COMMITS*5-1:0]    in_waddr,
    input  logic [COMMITS*XLEN-1:0] in_wdata,
    output logic                    in_ready,
`ifdef CJ_COMMIT_TRAP_EN
    input  logic                    trap_valid,
    input  logic [XLEN-1:0]         trap_cause,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_kind,
    output logic [XLEN-1:0]         out_pc,
    output logic [31:0]             out_insn,
    output logic                    out_wen,
    output logic [4:0]              out_waddr,
    output logic [XLEN-1:0]         out_wdata,
    output logic [31:0]             out_seq,
    output logic                    overflow
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(COMMITS + 2);

`ifdef CJ_COMMIT_TRAP_EN
    localparam int unsigned THRESH = COMMITS + 1;
    typedef commit_entry_t slot_t;
`else
    localparam int unsigned THRESH = COMMITS;
    typedef commit_payload_t slot_t;
`endif

    slot_t                         r_mem [DEPTH];
    slot_t                         r_head;
    slot_t                         w_head_next;
    slot_t                         w_lane [COMMITS];
    logic [IDX_W-1:0]              w_slot [COMMITS];
    logic [COMMITS-1:0][CNT_W-1:0] w_off;
    logic [CNT_W-1:0]              w_n;
    logic                          w_trap;
    logic [PTR_W-1:0]              r_wptr, r_rptr;
    logic [PTR_W-1:0]              w_wptr_next, w_rptr_next;
    logic [PTR_W-1:0]              w_count, w_free, w_count_next;
    logic                          w_deq, w_drop, w_enq;
    logic [31:0]                   r_seq;
    logic                          r_overflow, r_out_valid, r_in_ready;

`ifdef CJ_COMMIT_TRAP_EN
    slot_t            w_trap_entry;
    logic [IDX_W-1:0] w_trap_slot;
    assign w_trap = trap_valid;
`else
    assign w_trap = 1'b0;
`endif

    cj_lane_compactor #(
        .COMMITS (COMMITS),
        .CNT_W   (CNT_W)
    ) u_compactor (
        .i_valid (in_valid),
        .i_trap  (w_trap),
        .o_off   (w_off),
        .o_n     (w_n)
    );

    // Space check uses the registered occupancy only: same-cycle dequeue gives no credit
    assign w_count      = r_wptr - r_rptr;
    assign w_free       = PTR_W'(DEPTH) - w_count;
    assign w_drop       = PTR_W'(w_n) > w_free;
    assign w_enq        = (w_n != '0) && !w_drop;
    assign w_deq        = r_out_valid && out_ready;
    assign w_rptr_next  = r_rptr + PTR_W'(w_deq);
    assign w_wptr_next  = w_enq ? (r_wptr + PTR_W'(w_n)) : r_wptr;
    assign w_count_next = w_wptr_next - w_rptr_next;

    always_comb begin
        for (int i = 0; i < COMMITS; i++) begin
            w_lane[i] = '0;
`ifdef CJ_COMMIT_TRAP_EN
            w_lane[i].kind = EVENT_KIND_COMMIT;
`endif
            w_lane[i].pc    = in_pc[i*XLEN +: XLEN];
            w_lane[i].insn  = in_insn[i*32 +: 32];
            w_lane[i].wen   = in_wen[i];
            w_lane[i].waddr = in_waddr[i*5 +: 5];
            w_lane[i].wdata = in_wdata[i*XLEN +: XLEN];
            w_slot[i]       = r_wptr[IDX_W-1:0] + IDX_W'(w_off[i]);
        end
`ifdef CJ_COMMIT_TRAP_EN
        w_trap_entry       = '0;
        w_trap_entry.kind  = EVENT_KIND_TRAP;
        w_trap_entry.wdata = trap_cause;
        w_trap_slot        = r_wptr[IDX_W-1:0] + IDX_W'(w_n - CNT_W'(1));
`endif
    end

    // Next head: stored entry, or the entry being written into the head slot this cycle
    always_comb begin
        w_head_next = r_mem[w_rptr_next[IDX_W-1:0]];
        if (w_enq) begin
            for (int i = 0; i < COMMITS; i++) begin
                if (in_valid[i] && (w_slot[i] == w_rptr_next[IDX_W-1:0])) begin
                    w_head_next = w_lane[i];
                end
            end
`ifdef CJ_COMMIT_TRAP_EN
            if (trap_valid && (w_trap_slot == w_rptr_next[IDX_W-1:0])) begin
                w_head_next = w_trap_entry;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (w_enq) begin
            for (int i = 0; i < COMMITS; i++) begin
                if (in_valid[i]) begin
                    r_mem[w_slot[i]] <= w_lane[i];
                end
            end
`ifdef CJ_COMMIT_TRAP_EN
            if (trap_valid) begin
                r_mem[w_trap_slot] <= w_trap_entry;
            end
`endif
        end
        r_head <= w_head_next;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_seq       <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_wptr      <= w_wptr_next;
            r_rptr      <= w_rptr_next;
            r_overflow  <= r_overflow | w_drop;
            r_out_valid <= w_count_next != '0;
            r_in_ready  <= (PTR_W'(DEPTH) - w_count_next) >= PTR_W'(THRESH);
            if (w_deq) begin
                r_seq <= r_seq + 32'd1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_pc    = r_head.pc;
    assign out_insn  = r_head.insn;
    assign out_wen   = r_head.wen;
    assign out_waddr = r_head.waddr;
    assign out_wdata = r_head.wdata;
    assign out_seq   = r_seq;
    assign overflow  = r_overflow;
`ifdef CJ_COMMIT_TRAP_EN
    assign out_kind  = r_head.kind;
`else
    assign out_kind  = EVENT_KIND_COMMIT;
`endif

endmodule
